// File: rtl/ldtu_frame_ctrl.sv
// rtl/ldtu_frame_ctrl.sv - LiteDTU framing control: frame accounting, trailer insertion, output queue
//
// Ports:
//   CLK, rst_b         clock (rising edge), asynchronous active-low reset
//   fallback           1 = fallback mode, words pass through without framing
//   frame_len          data words per frame, 0 disables framing
//   load_data/data_in  normal-mode encoded word strobe and data
//   load_data_fb/data_fb fallback-mode word strobe and data
//   full               downstream cannot accept a write this cycle
//   handshake          downstream read request
//   data_out           registered output word
//   write_signal       data_out carries a new word this cycle
//   read_signal        handshake delayed by one cycle
//   losing_data        one-cycle pulse per dropped input word
//   lost_cnt           saturating dropped-word count
//   frame_id           id of the frame currently accumulating
module ldtu_frame_ctrl #(
    parameter int                    DATA_W    = 32,
    parameter int                    CRC_W     = 12,
    parameter logic [CRC_W-1:0]      CRC_POLY  = 12'h80F,
    parameter int                    NSAMP_W   = 8,
    parameter int                    FID_W     = 8,
    parameter int                    LEN_W     = 6,
    parameter int                    QDEPTH    = 4,
    parameter int                    LOSTC_W   = 16,
    parameter logic [DATA_W-1:0]     INIT_WORD = 32'hF000_0000
) (
    input  logic                CLK,
    input  logic                rst_b,
    input  logic                fallback,
    input  logic [LEN_W-1:0]    frame_len,
    input  logic                load_data,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                load_data_fb,
    input  logic [DATA_W-1:0]   data_fb,
    input  logic                full,
    input  logic                handshake,
    output logic [DATA_W-1:0]   data_out,
    output logic                write_signal,
    output logic                read_signal,
    output logic                losing_data,
    output logic [LOSTC_W-1:0]  lost_cnt,
    output logic [FID_W-1:0]    frame_id
);

    localparam int QAW = $clog2(QDEPTH);

    // Number of samples represented by an encoded word, from its header byte.
    function automatic logic [NSAMP_W-1:0] samp_weight(input logic [DATA_W-1:0] w);
        logic [7:0] h;
        h = w[DATA_W-1 -: 8];
        samp_weight = '0;
        case (h[7:6])
            2'b01:   samp_weight = NSAMP_W'(5);
            2'b10:   samp_weight = NSAMP_W'(h[5:0]);
            2'b00:   samp_weight = (h[7:2] == 6'b001010) ? NSAMP_W'(2) : NSAMP_W'(1);
            default: samp_weight = '0;
        endcase
    endfunction

    // MSB-first serial CRC over one whole word.
    function automatic logic [CRC_W-1:0] crc_next(input logic [CRC_W-1:0] c,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        return r;
    endfunction

    logic [DATA_W-1:0]  q_mem [QDEPTH];
    logic [QAW-1:0]     wr_ptr;
    logic [QAW-1:0]     rd_ptr;
    logic [QAW:0]       q_cnt;

    logic [LEN_W-1:0]   word_cnt;
    logic [NSAMP_W-1:0] nsamp;
    logic [CRC_W-1:0]   crc;
    logic [DATA_W-1:0]  trl_reg;
    logic               trl_pend;

    logic               in_vld;
    logic [DATA_W-1:0]  in_word;
    logic               acc_en;
    logic               close;
    logic [NSAMP_W-1:0] nsamp_n;
    logic [CRC_W-1:0]   crc_n;
    logic [QAW:0]       free;
    logic               trl_push;
    logic               in_push;
    logic               do_pop;
    logic [QAW-1:0]     in_idx;

    always_comb begin
        in_vld  = fallback ? load_data_fb : load_data;
        in_word = fallback ? data_fb : data_in;
        acc_en  = in_vld & ~fallback & (frame_len != '0);
        // One extra bit so word_cnt+1 cannot wrap when frame_len was lowered.
        close   = acc_en & (({1'b0, word_cnt} + (LEN_W+1)'(1)) >= {1'b0, frame_len});
        nsamp_n = nsamp + samp_weight(in_word);
        crc_n   = crc_next(crc, in_word);
        // Space is judged before the edge; a same-cycle pop frees nothing.
        free    = (QAW+1)'(QDEPTH) - q_cnt;
        // A pending trailer goes first. When it cannot push, free is zero, so
        // the input word is necessarily refused and ordering is preserved.
        trl_push = trl_pend & (free != '0);
        in_push  = in_vld & (free > (QAW+1)'(trl_push));
        do_pop   = ~full & (q_cnt != '0);
        in_idx   = wr_ptr + QAW'(trl_push);
    end

    // Queue storage carries no reset; validity is tracked by q_cnt.
    always_ff @(posedge CLK) begin
        if (trl_push) q_mem[wr_ptr] <= trl_reg;
        if (in_push)  q_mem[in_idx] <= in_word;
    end

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            q_cnt        <= '0;
            word_cnt     <= '0;
            nsamp        <= '0;
            crc          <= '0;
            trl_reg      <= '0;
            trl_pend     <= 1'b0;
            frame_id     <= '0;
            data_out     <= INIT_WORD;
            write_signal <= 1'b0;
            read_signal  <= 1'b0;
            losing_data  <= 1'b0;
            lost_cnt     <= '0;
        end else begin
            wr_ptr <= wr_ptr + QAW'(trl_push) + QAW'(in_push);
            rd_ptr <= rd_ptr + QAW'(do_pop);
            q_cnt  <= q_cnt + (QAW+1)'(trl_push) + (QAW+1)'(in_push) - (QAW+1)'(do_pop);

            write_signal <= do_pop;
            if (do_pop) data_out <= q_mem[rd_ptr];

            read_signal <= handshake;
            losing_data <= in_vld & ~in_push;
            if (in_vld & ~in_push & ~(&lost_cnt)) lost_cnt <= lost_cnt + LOSTC_W'(1);

            if (fallback) begin
                // Partial frame is abandoned; framing restarts from id 0.
                word_cnt <= '0;
                nsamp    <= '0;
                crc      <= '0;
                frame_id <= '0;
                trl_pend <= 1'b0;
            end else begin
                if (close)         trl_pend <= 1'b1;
                else if (trl_push) trl_pend <= 1'b0;

                if (close) begin
                    trl_reg  <= {4'b1101, nsamp_n, crc_n, frame_id};
                    word_cnt <= '0;
                    nsamp    <= '0;
                    crc      <= '0;
                    frame_id <= frame_id + FID_W'(1);
                end else if (acc_en) begin
                    word_cnt <= word_cnt + LEN_W'(1);
                    nsamp    <= nsamp_n;
                    crc      <= crc_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_ldtu_frame_ctrl.sv
// tb/tb_ldtu_frame_ctrl.sv - self-checking bench for ldtu_frame_ctrl
module tb_ldtu_frame_ctrl;

    localparam int QD = 4;

    logic        CLK;
    logic        rst_b;
    logic        fallback;
    logic [5:0]  frame_len;
    logic        load_data;
    logic [31:0] data_in;
    logic        load_data_fb;
    logic [31:0] data_fb;
    logic        full;
    logic        handshake;
    logic [31:0] data_out;
    logic        write_signal;
    logic        read_signal;
    logic        losing_data;
    logic [15:0] lost_cnt;
    logic [7:0]  frame_id;

    ldtu_frame_ctrl dut (
        .CLK(CLK), .rst_b(rst_b), .fallback(fallback), .frame_len(frame_len),
        .load_data(load_data), .data_in(data_in), .load_data_fb(load_data_fb),
        .data_fb(data_fb), .full(full), .handshake(handshake), .data_out(data_out),
        .write_signal(write_signal), .read_signal(read_signal),
        .losing_data(losing_data), .lost_cnt(lost_cnt), .frame_id(frame_id)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int n_lose = 0;
    logic [31:0] obs[$];
    int          obs_cyc[$];

    // Reference model state (transaction level: a word queue plus frame tallies)
    logic [31:0] mq[$];
    int          m_wc, m_ns, m_fid, m_lost;
    logic [11:0] m_crc;
    bit          m_tpend, m_ws, m_ld, m_rs;
    logic [31:0] m_trl, m_dout;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        else n_pass++;
    endtask

    function automatic int weight(input logic [31:0] w);
        int h;
        h = int'(w[31:24]);
        if (h >= 192) return 0;
        if (h >= 128) return h - 128;
        if (h >= 64)  return 5;
        if (h / 4 == 10) return 2;
        return 1;
    endfunction

    // CRC as the remainder of polynomial long division of the augmented message.
    function automatic logic [11:0] crcf(input logic [11:0] c, input logic [31:0] w);
        logic [43:0] v;
        logic [12:0] g;
        g = 13'h180F;
        v = {c, 32'b0} ^ {w, 12'b0};
        for (int i = 43; i >= 12; i--)
            if (v[i]) v[i -: 13] = v[i -: 13] ^ g;
        return v[11:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wc = 0; m_ns = 0; m_fid = 0; m_lost = 0; m_crc = '0;
        m_tpend = 0; m_ws = 0; m_ld = 0; m_rs = 0; m_trl = '0; m_dout = 32'hF000_0000;
    endtask

    task automatic model_step();
        bit vld, tpush, ipush, pop;
        logic [31:0] w;
        int free;
        vld   = fallback ? load_data_fb : load_data;
        w     = fallback ? data_fb : data_in;
        free  = QD - mq.size();
        pop   = !full && mq.size() > 0;
        tpush = m_tpend && free >= 1;
        ipush = vld && (free - int'(tpush)) >= 1;
        m_ws  = pop;
        if (pop)   m_dout = mq.pop_front();
        if (tpush) mq.push_back(m_trl);
        if (ipush) mq.push_back(w);
        m_ld = vld && !ipush;
        if (m_ld && m_lost < 65535) m_lost++;
        m_rs = handshake;
        if (tpush) m_tpend = 0;
        if (fallback) begin
            m_wc = 0; m_ns = 0; m_crc = '0; m_fid = 0; m_tpend = 0;
        end else if (frame_len != 0 && vld) begin
            m_wc++;
            m_ns  = (m_ns + weight(w)) % 256;
            m_crc = crcf(m_crc, w);
            if (m_wc >= int'(frame_len)) begin
                m_trl   = {4'hD, 8'(m_ns), m_crc, 8'(m_fid)};
                m_tpend = 1;
                m_wc = 0; m_ns = 0; m_crc = '0;
                m_fid = (m_fid + 1) % 256;
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
        cyc++;
        chk("write_signal", write_signal, m_ws);
        chk("data_out", data_out, m_dout);
        chk("losing_data", losing_data, m_ld);
        chk("lost_cnt", lost_cnt, 16'(m_lost));
        chk("frame_id", frame_id, 8'(m_fid));
        chk("read_signal", read_signal, m_rs);
        if (write_signal) begin
            obs.push_back(data_out);
            obs_cyc.push_back(cyc);
        end
        if (losing_data) n_lose++;
    endtask

    task automatic idle(input int n);
        load_data = 0; load_data_fb = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [31:0] w);
        load_data = 1; data_in = w;
        step();
        load_data = 0;
    endtask

    task automatic clear_obs();
        obs.delete(); obs_cyc.delete(); n_lose = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data_out"}, data_out, 32'hF000_0000);
        chk({tag, "_write_signal"}, write_signal, 1'b0);
        chk({tag, "_read_signal"}, read_signal, 1'b0);
        chk({tag, "_losing_data"}, losing_data, 1'b0);
        chk({tag, "_lost_cnt"}, lost_cnt, 16'h0);
        chk({tag, "_frame_id"}, frame_id, 8'h0);
    endtask

    task automatic do_reset();
        rst_b = 0; fallback = 0; frame_len = 0; load_data = 0; data_in = 0;
        load_data_fb = 0; data_fb = 0; full = 0; handshake = 0;
        @(negedge CLK);
        @(negedge CLK);
        chk_reset_vals("reset");
        rst_b = 1;
        model_reset();
        clear_obs();
    endtask

    typedef struct {
        logic [7:0] hdr;
        int         exp_w;
    } wvec_t;

    wvec_t wtab[11];

    initial begin
        logic [11:0] c;
        int s0;
        wtab[0]  = '{8'h40, 5};  wtab[1]  = '{8'h7F, 5};  wtab[2]  = '{8'h8A, 10};
        wtab[3]  = '{8'hBF, 63}; wtab[4]  = '{8'h80, 0};  wtab[5]  = '{8'h28, 2};
        wtab[6]  = '{8'h2B, 2};  wtab[7]  = '{8'h2C, 1};  wtab[8]  = '{8'h01, 1};
        wtab[9]  = '{8'hC0, 0};  wtab[10] = '{8'hFF, 0};

        do_reset();

        // Basic frame of three weight-5 words
        frame_len = 3;
        send(32'h4000_0001);
        s0 = cyc;
        send(32'h4000_0002);
        send(32'h4000_0003);
        idle(5);
        c = crcf(crcf(crcf(12'h0, 32'h4000_0001), 32'h4000_0002), 32'h4000_0003);
        chk("basic_count", obs.size(), 4);
        chk("basic_w0", obs.size() > 0 ? obs[0] : 32'hDEAD, 32'h4000_0001);
        chk("basic_w2", obs.size() > 2 ? obs[2] : 32'hDEAD, 32'h4000_0003);
        chk("basic_trailer", obs.size() > 3 ? obs[3] : 32'hDEAD, {12'hD0F, c, 8'h00});
        chk("basic_first_cycle", obs_cyc.size() > 0 ? obs_cyc[0] : -1, s0 + 1);
        chk("basic_last_cycle", obs_cyc.size() > 3 ? obs_cyc[3] : -1, s0 + 4);
        chk("basic_frame_id", frame_id, 8'h01);

        // Mixed weights in one frame
        clear_obs();
        frame_len = 4;
        send(32'h2812_3456); send(32'h8A00_0001); send(32'hC0FF_FFFF); send(32'h0100_0000);
        idle(4);
        chk("weights_count", obs.size(), 5);
        chk("weights_nsamp", obs.size() > 4 ? obs[4][27:20] : 8'hEE, 8'h0D);

        // Weight table, one word per frame
        frame_len = 1;
        foreach (wtab[i]) begin
            clear_obs();
            send({wtab[i].hdr, 24'hABCDEF});
            idle(3);
            chk("wt_count", obs.size(), 2);
            chk($sformatf("wt_nsamp_%0h", wtab[i].hdr),
                obs.size() > 1 ? 64'(obs[1][27:20]) : 64'hDEAD, 64'(wtab[i].exp_w));
        end

        // Back-pressure absorbed by the queue
        do_reset();
        full = 1;
        send(32'h0000_0011); send(32'h0000_0022); send(32'h0000_0033);
        full = 0;
        idle(5);
        chk("bp_no_loss", n_lose, 0);
        chk("bp_count", obs.size(), 3);
        chk("bp_order", obs.size() > 2 ? {obs[0][7:0], obs[1][7:0], obs[2][7:0]} : 24'h0, 24'h112233);

        // Overflow: six words against a four-entry queue
        clear_obs();
        full = 1;
        for (int i = 1; i <= 6; i++) send(32'h0000_0100 + i);
        full = 0;
        idle(6);
        chk("ovf_pulses", n_lose, 2);
        chk("ovf_lost_cnt", lost_cnt, 16'd2);
        chk("ovf_count", obs.size(), 4);
        chk("ovf_last", obs.size() > 3 ? obs[3] : 32'hDEAD, 32'h0000_0104);

        // Fallback mid-frame: no trailer, words pass unmodified
        do_reset();
        frame_len = 3;
        send(32'h4000_00A1); send(32'h4000_00A2);
        fallback = 1;
        load_data = 1; data_in = 32'h5555_5555;
        load_data_fb = 1; data_fb = 32'hFB00_0001; step();
        data_fb = 32'hFB00_0002; step();
        idle(4);
        fallback = 0;
        idle(1);
        chk("fb_count", obs.size(), 4);
        chk("fb_word0", obs.size() > 2 ? obs[2] : 32'hDEAD, 32'hFB00_0001);
        chk("fb_word1", obs.size() > 3 ? obs[3] : 32'hDEAD, 32'hFB00_0002);
        chk("fb_frame_id", frame_id, 8'h00);

        // Randomized traffic against the model
        do_reset();
        frame_len = 3;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) fallback = ~fallback;
            if ($urandom_range(0, 29) == 0) frame_len = 6'($urandom_range(0, 7));
            load_data    = ($urandom_range(0, 9) < 7);
            data_in      = $urandom;
            load_data_fb = ($urandom_range(0, 9) < 6);
            data_fb      = $urandom;
            full         = ($urandom_range(0, 9) < 3);
            handshake    = 1'($urandom);
            step();
        end
        fallback = 0; full = 0; handshake = 0;
        idle(6);

        // Asynchronous reset with a non-empty queue
        do_reset();
        full = 1;
        for (int i = 0; i < 5; i++) send(32'h0C0C_0000 + i);
        full = 0;
        handshake = 1;
        step();
        chk("arst_pre_ws", write_signal, 1'b1);
        #2;
        rst_b = 0;
        #1;
        chk_reset_vals("arst");
        model_reset();
        handshake = 0;
        @(negedge CLK);
        rst_b = 1;
        idle(3);
        chk("arst_no_output", obs.size() > 0 ? obs[obs.size()-1] : 32'hF000_0000, 32'h0C0C_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
